// File: rtl/freq_sweep_scheduler.sv
// Frequency sweep sequencer: steps an offset word from a start to a stop bound and
// drives the updater's FREQW/UPDATE handshake, dwelling a programmable time per point.
module freq_sweep_scheduler #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        CONT,
  input  logic        DIR,
  input  logic [31:0] START_FREQW,
  input  logic [31:0] STOP_FREQW,
  input  logic [31:0] STEP_FREQW,
  input  logic [15:0] DWELL,
  input  logic        INITIED,
  input  logic        UPDATED,
  output logic [31:0] FREQW,
  output logic        UPDATE,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] SWEEP_IDX,
  output logic        ERROR
);

  localparam int unsigned TimeoutW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StReq,
    StWaitAck,
    StDwell,
    StNext
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         freqw_q, freqw_d;
  logic [15:0]         idx_q, idx_d;
  logic                error_q, error_d;
  logic                done_q, done_d;
  logic                update_q, update_d;
  logic                req_cnt_q, req_cnt_d;
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]         dwell_cnt_q, dwell_cnt_d;

  // Configuration shadows, frozen for the whole sweep.
  logic                cont_q, cont_d;
  logic                dir_q, dir_d;
  logic [31:0]         start_q, start_d;
  logic [31:0]         stop_q, stop_d;
  logic [31:0]         step_q, step_d;
  logic [15:0]         dwell_q, dwell_d;

  logic [32:0]         cand;
  logic                finished;
  logic                needs_init;

  // Bit 32 carries the overflow (ascending) or borrow (descending).
  always_comb begin
    if (dir_q) begin
      cand = {1'b0, freqw_q} - {1'b0, step_q};
    end else begin
      cand = {1'b0, freqw_q} + {1'b0, step_q};
    end
  end

  assign finished = (step_q == '0) || cand[32] ||
                    (dir_q ? (cand[31:0] < stop_q) : (cand[31:0] > stop_q));

  assign needs_init = (state_q == StReq) || (state_q == StWaitAck) ||
                      (state_q == StDwell) || (state_q == StNext);

  always_comb begin
    state_d     = state_q;
    freqw_d     = freqw_q;
    idx_d       = idx_q;
    error_d     = error_q;
    done_d      = 1'b0;
    req_cnt_d   = req_cnt_q;
    to_cnt_d    = to_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    cont_d      = cont_q;
    dir_d       = dir_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;

    if (ABORT && (state_q != StIdle)) begin
      state_d = StIdle;
    end else if (needs_init && !INITIED) begin
      error_d = 1'b1;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (START && !ABORT) begin
            cont_d  = CONT;
            dir_d   = DIR;
            start_d = START_FREQW;
            stop_d  = STOP_FREQW;
            step_d  = STEP_FREQW;
            dwell_d = DWELL;
            freqw_d = START_FREQW;
            idx_d   = '0;
            error_d = 1'b0;
            state_d = StWaitInit;
          end
        end
        StWaitInit: begin
          if (INITIED) begin
            state_d = StReq;
          end
        end
        StReq: begin
          if (req_cnt_q) begin
            to_cnt_d = '0;
            state_d  = StWaitAck;
          end else begin
            req_cnt_d = 1'b1;
          end
        end
        StWaitAck: begin
          if (UPDATED) begin
            dwell_cnt_d = dwell_q;
            state_d     = StDwell;
          end else if (to_cnt_q == TimeoutLast) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        StDwell: begin
          if (dwell_cnt_q == '0) begin
            state_d = StNext;
          end else begin
            dwell_cnt_d = dwell_cnt_q - 16'd1;
          end
        end
        StNext: begin
          if (!finished) begin
            freqw_d = cand[31:0];
            idx_d   = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
            state_d = StReq;
          end else if (cont_q) begin
            freqw_d = start_q;
            idx_d   = '0;
            state_d = StReq;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Every REQ entry must see a fresh two-cycle request window.
    if (state_d != StReq) begin
      req_cnt_d = 1'b0;
    end
    update_d = (state_d == StReq);
  end

  always_ff @(posedge CLOCK_10M) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      freqw_q     <= '0;
      idx_q       <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      update_q    <= 1'b0;
      req_cnt_q   <= 1'b0;
      to_cnt_q    <= '0;
      dwell_cnt_q <= '0;
      cont_q      <= 1'b0;
      dir_q       <= 1'b0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      freqw_q     <= freqw_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
      done_q      <= done_d;
      update_q    <= update_d;
      req_cnt_q   <= req_cnt_d;
      to_cnt_q    <= to_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      cont_q      <= cont_d;
      dir_q       <= dir_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
    end
  end

  assign FREQW     = freqw_q;
  assign UPDATE    = update_q;
  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;
  assign SWEEP_IDX = idx_q;
  assign ERROR     = error_q;

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Bench for freq_sweep_scheduler: an updater model acks requests, and a list-based sweep
// model predicts each issued point, its index and the point period.
module tb_freq_sweep_scheduler;

  localparam int unsigned TimeoutCycles = 16;
  localparam longint MaxWord = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, cont, dir, initied, updated;
  logic [31:0] start_freqw, stop_freqw, step_freqw;
  logic [15:0] dwell;
  logic [31:0] freqw;
  logic        update, busy, done, error;
  logic [15:0] sweep_idx;

  int          n_tests = 0;
  int          n_fail = 0;

  // Sweep configuration and updater behaviour for the next run.
  bit          c_dir, c_cont;
  logic [31:0] c_start, c_stop, c_step;
  logic [15:0] c_dwell;
  int          ack_lat = 5;
  bit          no_ack = 1'b0;
  int          ack_cnt;
  bit          upd_prev;

  logic [31:0] exp_q[$];
  int          exp_idx[$];

  always #50 clk = ~clk;

  freq_sweep_scheduler #(
    .TIMEOUT(TimeoutCycles)
  ) dut (
    .CLOCK_10M  (clk),
    .RESET_N    (rst_n),
    .START      (start),
    .ABORT      (abort),
    .CONT       (cont),
    .DIR        (dir),
    .START_FREQW(start_freqw),
    .STOP_FREQW (stop_freqw),
    .STEP_FREQW (step_freqw),
    .DWELL      (dwell),
    .INITIED    (initied),
    .UPDATED    (updated),
    .FREQW      (freqw),
    .UPDATE     (update),
    .BUSY       (busy),
    .DONE       (done),
    .SWEEP_IDX  (sweep_idx),
    .ERROR      (error)
  );

  // Updater: on a new request it drops UPDATED and raises it ack_lat cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        updated  = 1'b0;
        ack_cnt  = 0;
        upd_prev = 1'b0;
      end else begin
        if (update && !upd_prev) begin
          updated = 1'b0;
          ack_cnt = ack_lat;
        end else if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0 && !no_ack) updated = 1'b1;
        end
        upd_prev = update;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // List of points the sweep must issue, from the stepping rules alone.
  task automatic build_expected();
    longint p, nx, e, st;
    int     idx;
    exp_q.delete();
    exp_idx.delete();
    p   = longint'(c_start);
    e   = longint'(c_stop);
    st  = longint'(c_step);
    idx = 0;
    while (exp_q.size() < 200) begin
      exp_q.push_back(32'(p));
      exp_idx.push_back(idx);
      nx = c_dir ? p - st : p + st;
      if (st == 0 || nx < 0 || nx > MaxWord || (!c_dir && nx > e) || (c_dir && nx < e)) begin
        if (!c_cont) break;
        p   = longint'(c_start);
        idx = 0;
      end else begin
        p   = nx;
        idx = (idx == 65535) ? 65535 : idx + 1;
      end
    end
  endtask

  // Call at a falling edge; returns one falling edge after START was sampled.
  task automatic start_sweep();
    cont        = c_cont;
    dir         = c_dir;
    start_freqw = c_start;
    stop_freqw  = c_stop;
    step_freqw  = c_step;
    dwell       = c_dwell;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    // Live inputs change after START; only the captured copies may matter.
    start_freqw = ~c_start;
    stop_freqw  = $urandom;
    step_freqw  = $urandom;
    dwell       = 16'($urandom);
    dir         = ~c_dir;
    cont        = ~c_cont;
  endtask

  task automatic wait_rise(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (update) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq({tag, "_rise"}, 64'(ok), 64'd1);
  endtask

  // Runs one sweep; abort_after > 0 aborts right as that many points have been requested.
  task automatic run_sweep(input string tag, input int abort_after);
    int seen = 0;
    int prev_rise = -1;
    int hi_len = 0;
    int dones = 0;
    bit prev_upd = 1'b0;
    build_expected();
    start_sweep();
    for (int cyc = 0; cyc < 4000 && dones == 0; cyc++) begin
      if (update && !prev_upd) begin
        if (seen < exp_q.size()) begin
          check_eq({tag, "_freqw"}, 64'(freqw), 64'(exp_q[seen]));
          check_eq({tag, "_idx"}, 64'(sweep_idx), 64'(exp_idx[seen]));
        end
        // REQ 2 + WAIT_ACK (ack_lat-1) + DWELL (dwell+1) + NEXT 1
        if (prev_rise >= 0) begin
          check_eq({tag, "_period"}, 64'(cyc - prev_rise), 64'(ack_lat + 3 + int'(c_dwell)));
        end
        prev_rise = cyc;
        seen++;
        if (abort_after > 0 && seen == abort_after) break;
      end
      if (!update && prev_upd) check_eq({tag, "_upd_width"}, 64'(hi_len), 64'd2);
      hi_len = update ? hi_len + 1 : 0;
      if (done) begin
        dones++;
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
      prev_upd = update;
      @(negedge clk);
    end
    if (abort_after > 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq({tag, "_abort_npts"}, 64'(seen), 64'(abort_after));
      check_eq({tag, "_abort_busy"}, 64'(busy), 64'd0);
      check_eq({tag, "_abort_upd"}, 64'(update), 64'd0);
      check_eq({tag, "_abort_err"}, 64'(error), 64'd0);
      check_eq({tag, "_abort_dones"}, 64'(dones + int'(done)), 64'd0);
    end else begin
      check_eq({tag, "_npts"}, 64'(seen), 64'(exp_q.size()));
      check_eq({tag, "_dones"}, 64'(dones), 64'd1);
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_eq({tag, "_freqw_end"}, 64'(freqw), 64'(exp_q[exp_q.size() - 1]));
      check_eq({tag, "_idx_end"}, 64'(sweep_idx), 64'(exp_idx[exp_idx.size() - 1]));
      check_eq({tag, "_err"}, 64'(error), 64'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_freqw"}, 64'(freqw), 64'd0);
    check_eq({tag, "_upd"}, 64'(update), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_idx"}, 64'(sweep_idx), 64'd0);
    check_eq({tag, "_err"}, 64'(error), 64'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0; dir = 1'b0; initied = 1'b1;
    start_freqw = '0; stop_freqw = '0; step_freqw = '0; dwell = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending 100..130 by 10.
    c_dir = 0; c_cont = 0; c_start = 100; c_stop = 130; c_step = 10; c_dwell = 3; ack_lat = 5;
    run_sweep("asc", 0);
    check_eq("asc_last_freqw", 64'(freqw), 64'd130);
    check_eq("asc_last_idx", 64'(sweep_idx), 64'd3);

    // Descending must stop before borrowing below zero.
    c_dir = 1; c_start = 20; c_stop = 0; c_step = 7; c_dwell = 0; ack_lat = 3;
    run_sweep("desc", 0);
    check_eq("desc_last_freqw", 64'(freqw), 64'd6);

    // Ascending carry out of 32 bits leaves a single point.
    c_dir = 0; c_start = 32'hFFFF_FFF0; c_stop = 32'hFFFF_FFFF; c_step = 32'h20; c_dwell = 2;
    run_sweep("wrap", 0);
    check_eq("wrap_last_freqw", 64'(freqw), 64'hFFFF_FFF0);

    // Continuous 0,1,2,0,... aborted after 7 points.
    c_cont = 1; c_start = 0; c_stop = 2; c_step = 1; c_dwell = 1; ack_lat = 4;
    run_sweep("cont", 7);
    c_cont = 0;

    // START while the DDS is not initialised, then INITIED loss during DWELL.
    c_start = 5; c_stop = 1000; c_step = 1; c_dwell = 20; ack_lat = 5;
    initied = 1'b0;
    start_sweep();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (update || !busy) bad++;
      @(negedge clk);
    end
    check_eq("winit_hold", 64'(bad), 64'd0);
    initied = 1'b1;
    @(negedge clk);
    check_eq("winit_first_upd", 64'(update), 64'd1);
    bad = 1;
    for (int i = 0; i < 60; i++) begin
      if (updated) begin
        bad = 0;
        break;
      end
      @(negedge clk);
    end
    check_eq("winit_acked", 64'(bad), 64'd0);
    repeat (3) @(negedge clk);
    initied = 1'b0;
    @(negedge clk);
    check_eq("initloss_err", 64'(error), 64'd1);
    check_eq("initloss_busy", 64'(busy), 64'd0);
    check_eq("initloss_done", 64'(done), 64'd0);
    initied = 1'b1;
    @(negedge clk);

    // Updater never acknowledges.
    c_start = 40; c_stop = 80; c_step = 4; c_dwell = 1; no_ack = 1'b1;
    start_sweep();
    wait_rise("tmo");
    repeat (17) @(negedge clk);
    check_eq("tmo_busy_before", 64'(busy), 64'd1);
    check_eq("tmo_err_before", 64'(error), 64'd0);
    @(negedge clk);
    check_eq("tmo_err", 64'(error), 64'd1);
    check_eq("tmo_busy", 64'(busy), 64'd0);
    no_ack = 1'b0;
    start_sweep();
    check_eq("tmo_err_cleared", 64'(error), 64'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Reset pulse while waiting for the second point's acknowledge.
    c_start = 1000; c_stop = 2000; c_step = 50; c_dwell = 2; ack_lat = 8;
    start_sweep();
    wait_rise("rst1");
    repeat (2) @(negedge clk);
    wait_rise("rst2");
    check_eq("rst_idx_before", 64'(sweep_idx), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("midreset");
    @(negedge clk);

    // Randomized single sweeps.
    for (int t = 0; t < 10; t++) begin
      int          r;
      logic [31:0] j;
      c_dir   = 1'($urandom_range(0, 1));
      c_cont  = 0;
      c_start = $urandom;
      case ($urandom_range(0, 3))
        0:       c_step = 32'd0;
        1:       c_step = $urandom | 32'h1000_0000;
        default: c_step = 32'($urandom_range(1, 1000));
      endcase
      r = int'($urandom_range(0, 6));
      j = (c_step == 0) ? 32'($urandom_range(0, 5)) : $urandom % c_step;
      c_stop  = c_dir ? c_start - c_step * 32'(r) - j : c_start + c_step * 32'(r) + j;
      c_dwell = 16'($urandom_range(0, 6));
      ack_lat = int'($urandom_range(2, 8));
      run_sweep($sformatf("rnd%0d", t), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
